syscall_console: RTL

//  Synthesizable syscall service stage that sits directly downstream of the processor's syscall trap.
//  On a sysEnable request it latches $v0 (code) and $a0 (argument), then runs the service.

---
 rtl/syscall_console_if.sv | 30 +++
 rtl/syscall_console.sv | 116 +++++++++++
 2 files changed

// File: rtl/syscall_console_if.sv
// syscall_console_if: request, data-memory read and character-stream signals of the syscall console
//   slave  : the console itself (takes requests, issues reads, sources characters)
//   master : the surrounding core, memory and console sink
//   sysEnable/sysCode/sysArg  request with $v0/$a0
//   busy/done/badCode/halt    service status
//   memRead/memAddr/memData   word read port, data one cycle after the strobe
//   charData/charValid/charReady  output byte stream
interface syscall_console_if #(parameter int ADDR_W = 9);
    logic              sysEnable;
    logic [31:0]       sysCode;
    logic [31:0]       sysArg;
    logic              busy;
    logic              done;
    logic              badCode;
    logic              halt;
    logic              memRead;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memData;
    logic [7:0]        charData;
    logic              charValid;
    logic              charReady;
    modport slave (
        input  sysEnable, sysCode, sysArg, memData, charReady,
        output busy, done, badCode, halt, memRead, memAddr, charData, charValid
    );
    modport master (
        output sysEnable, sysCode, sysArg, memData, charReady,
        input  busy, done, badCode, halt, memRead, memAddr, charData, charValid
    );
endinterface

// File: rtl/syscall_console.sv
// syscall_console: services print-int, print-string and exit syscalls as a valid/ready byte stream
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : syscall_console_if.slave carrying the request, memory-read and character ports
module syscall_console #(
    parameter int ADDR_W  = 9,
    parameter int MAX_LEN = 2048
) (
    input  logic            clk,
    input  logic            rst_n,
    syscall_console_if.slave bus
);
    localparam int IW = ADDR_W + 2;
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, NUM_CONV, NUM_EMIT, NL_EMIT, STR_REQ, STR_WAIT, STR_EMIT, FINISH, HALTED
    } state_t;

    state_t        state, nxt;
    logic [31:0]   mag;
    logic [31:0]   q10;
    logic [3:0]    digit;
    logic [3:0]    stk [10];
    logic [3:0]    sp;
    logic          neg_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [7:0]    byte_q;
    logic [7:0]    lane;
    logic          bad_q;
    logic          halt_seen;
    logic          accept;
    logic          char_valid;
    logic          xfer;

    assign accept     = state == IDLE && bus.sysEnable;
    assign q10        = mag / 32'd10;
    assign digit      = 4'(mag % 32'd10);
    assign lane       = idx[1] ? (idx[0] ? bus.memData[31:24] : bus.memData[23:16])
                               : (idx[0] ? bus.memData[15:8]  : bus.memData[7:0]);
    assign char_valid = state == NUM_EMIT || state == NL_EMIT || state == STR_EMIT;
    assign xfer       = char_valid && bus.charReady;

    // Outputs decode from registered state only, so charReady never reaches charValid
    // and an async reset clears the stream at once.
    assign bus.charValid = char_valid;
    assign bus.charData  = state == NL_EMIT  ? 8'h0A :
                           state == STR_EMIT ? byte_q :
                           state != NUM_EMIT ? 8'h00 :
                           neg_q             ? 8'h2D : {4'h3, stk[sp - 4'd1]};
    assign bus.busy      = state != IDLE && state != HALTED;
    assign bus.done      = state == FINISH || (state == HALTED && !halt_seen);
    assign bus.badCode   = state == FINISH && bad_q;
    assign bus.halt      = state == HALTED;
    assign bus.memRead   = state == STR_REQ;
    assign bus.memAddr   = idx[IW-1:2];

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (bus.sysEnable) nxt = bus.sysCode == 32'd1  ? NUM_CONV :
                                               bus.sysCode == 32'd4  ? STR_REQ  :
                                               bus.sysCode == 32'd10 ? HALTED   : FINISH;
            NUM_CONV: nxt = q10 == 32'd0 ? NUM_EMIT : NUM_CONV;
            NUM_EMIT: nxt = xfer && !neg_q && sp == 4'd1 ? NL_EMIT : NUM_EMIT;
            NL_EMIT:  nxt = xfer ? FINISH : NL_EMIT;
            STR_REQ:  nxt = STR_WAIT;
            STR_WAIT: nxt = lane == 8'h00 ? FINISH : STR_EMIT;
            STR_EMIT: nxt = !xfer ? STR_EMIT : cnt == CW'(MAX_LEN - 1) ? FINISH : STR_REQ;
            FINISH:   nxt = IDLE;
            default:  nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            sp        <= '0;
            neg_q     <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            byte_q    <= '0;
            bad_q     <= 1'b0;
            halt_seen <= 1'b0;
            for (int i = 0; i < 10; i++) stk[i] <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                // two's-complement negate leaves 0x80000000 as its unsigned magnitude
                neg_q <= bus.sysArg[31];
                mag   <= bus.sysArg[31] ? -bus.sysArg : bus.sysArg;
                sp    <= '0;
                idx   <= bus.sysArg[IW-1:0];
                cnt   <= '0;
                bad_q <= bus.sysCode != 32'd1 && bus.sysCode != 32'd4 && bus.sysCode != 32'd10;
            end
            if (state == NUM_CONV) begin
                stk[sp] <= digit;
                sp      <= sp + 4'd1;
                mag     <= q10;
            end
            // the sign goes out before any digit is popped
            if (state == NUM_EMIT && xfer) begin
                if (neg_q) neg_q <= 1'b0;
                else sp <= sp - 4'd1;
            end
            if (state == STR_WAIT) byte_q <= lane;
            if (state == STR_EMIT && xfer) begin
                idx <= idx + IW'(1);
                cnt <= cnt + CW'(1);
            end
            if (state == HALTED) halt_seen <= 1'b1;
        end
    end
endmodule
